// File: rtl/uart_cmd_bridge_if.sv
// ============================================================================
//  Module      : uart_cmd_bridge_if
//  Description : Byte-in / word-out bus bundle for uart_cmd_bridge.
//                rx_valid_i/rx_data_i carry one received byte per strobe;
//                m_axis_* is the AXI-Stream style command word output.
//                modport master : bridge side (consumes bytes, produces words)
//                modport slave  : environment side (produces bytes, sinks words)
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface uart_cmd_bridge_if #(
    parameter int DATA_W = 32
);
    logic              rx_valid_i;
    logic [7:0]        rx_data_i;
    logic              m_axis_tvalid_o;
    logic              m_axis_tready_i;
    logic [DATA_W-1:0] m_axis_tdata_o;

    modport master (
        input  rx_valid_i,
        input  rx_data_i,
        input  m_axis_tready_i,
        output m_axis_tvalid_o,
        output m_axis_tdata_o
    );

    modport slave (
        output rx_valid_i,
        output rx_data_i,
        output m_axis_tready_i,
        input  m_axis_tvalid_o,
        input  m_axis_tdata_o
    );
endinterface

`default_nettype wire

// File: rtl/uart_cmd_bridge.sv
// ============================================================================
//  Module      : uart_cmd_bridge
//  Description : Assembles received UART bytes into DATA_W-bit command words
//                and queues them in a small FIFO toward a stream consumer.
//                A partial word idle for TIMEOUT_CYC cycles is discarded.
//  Ports       : clk        - sole clock, rising edge
//                reset_i    - synchronous active-high reset
//                bus        - uart_cmd_bridge_if.master (bytes in, words out)
//                level_o    - FIFO occupancy 0..FIFO_DEPTH
//                overflow_o - sticky, a completed word was dropped (FIFO full)
//                timeout_o  - one-cycle pulse, a partial word was discarded
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_cmd_bridge #(
    parameter int DATA_W      = 32,
    parameter int FIFO_DEPTH  = 4,
    parameter int MSB_FIRST   = 1,
    parameter int TIMEOUT_CYC = 250000
) (
    input  wire logic                         clk,
    input  wire logic                         reset_i,
    uart_cmd_bridge_if.master                 bus,
    output logic [$clog2(FIFO_DEPTH):0]       level_o,
    output logic                              overflow_o,
    output logic                              timeout_o
);

    localparam int c_BYTES   = DATA_W / 8;
    localparam int c_CNT_W   = (c_BYTES > 1) ? $clog2(c_BYTES) : 1;
    localparam int c_PTR_W   = $clog2(FIFO_DEPTH);
    localparam int c_LVL_W   = c_PTR_W + 1;
    localparam bit c_TO_EN   = (TIMEOUT_CYC > 0);
    localparam int c_TO_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int c_TO_LAST = (TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0;

    typedef enum logic [0:0] {
        S_IDLE    = 1'b0,
        S_COLLECT = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_CNT_W-1:0]   r_byte_cnt;
    logic [c_CNT_W-1:0]   w_byte_cnt_nxt;
    logic [c_CNT_W-1:0]   w_lane;
    logic [DATA_W-1:0]    r_asm;
    logic [DATA_W-1:0]    w_word;
    logic [c_TO_W-1:0]    r_idle_cnt;
    logic                 r_timeout;
    logic                 r_overflow;
    logic                 w_last;
    logic                 w_push;
    logic                 w_timeout_hit;

    logic [DATA_W-1:0]    r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_LVL_W-1:0]   r_level;
    logic                 w_full;
    logic                 w_pop;
    logic                 w_wr;
    logic                 w_drop;

    // ------------------------------------------------------------------
    // Byte assembly
    // ------------------------------------------------------------------
    assign w_last = (r_byte_cnt == c_CNT_W'(c_BYTES - 1));
    assign w_lane = (MSB_FIRST != 0) ? (c_CNT_W'(c_BYTES - 1) - r_byte_cnt)
                                     : r_byte_cnt;

    // Word as it looks with the current byte merged in; on the final byte
    // this is what gets pushed, so the push needs no extra cycle.
    always_comb begin
        w_word = r_asm;
        w_word[8*int'(w_lane) +: 8] = bus.rx_data_i;
    end

    always_ff @(posedge clk) begin
        if (reset_i) begin
            r_state    <= S_IDLE;
            r_byte_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_byte_cnt <= w_byte_cnt_nxt;
        end
    end

    // A byte arriving in the expiry cycle wins over the timeout.
    always_comb begin
        w_state_nxt    = r_state;
        w_byte_cnt_nxt = r_byte_cnt;
        w_push         = 1'b0;
        w_timeout_hit  = 1'b0;
        if (bus.rx_valid_i) begin
            if (w_last) begin
                w_push         = 1'b1;
                w_byte_cnt_nxt = '0;
                w_state_nxt    = S_IDLE;
            end else begin
                w_byte_cnt_nxt = r_byte_cnt + c_CNT_W'(1);
                w_state_nxt    = S_COLLECT;
            end
        end else if (c_TO_EN && (r_state == S_COLLECT) &&
                     (r_idle_cnt == c_TO_W'(c_TO_LAST))) begin
            w_timeout_hit  = 1'b1;
            w_byte_cnt_nxt = '0;
            w_state_nxt    = S_IDLE;
        end
    end

    // Idle counter only runs while a partial word is pending.
    always_ff @(posedge clk) begin
        if (reset_i) begin
            r_idle_cnt <= '0;
            r_timeout  <= 1'b0;
        end else begin
            r_timeout <= w_timeout_hit;
            if (!c_TO_EN || bus.rx_valid_i || (r_state == S_IDLE) || w_timeout_hit)
                r_idle_cnt <= '0;
            else
                r_idle_cnt <= r_idle_cnt + c_TO_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Word FIFO
    // ------------------------------------------------------------------
    assign w_full = (r_level == c_LVL_W'(FIFO_DEPTH));
    assign w_pop  = (r_level != '0) && bus.m_axis_tready_i;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign w_wr   = w_push && (!w_full || w_pop);
    assign w_drop = w_push && w_full && !w_pop;

    // Datapath storage carries no reset; stale contents are never exposed
    // because tvalid follows the level and every lane is rewritten per word.
    always_ff @(posedge clk) begin
        if (bus.rx_valid_i)
            r_asm <= w_word;
        if (w_wr && !reset_i)
            r_mem[r_wr_ptr] <= w_word;
    end

    always_ff @(posedge clk) begin
        if (reset_i) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr)
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            case ({w_wr, w_pop})
                2'b10:   r_level <= r_level + c_LVL_W'(1);
                2'b01:   r_level <= r_level - c_LVL_W'(1);
                default: r_level <= r_level;
            endcase
            if (w_drop)
                r_overflow <= 1'b1;
        end
    end

    assign bus.m_axis_tvalid_o = (r_level != '0);
    assign bus.m_axis_tdata_o  = r_mem[r_rd_ptr];
    assign level_o             = r_level;
    assign overflow_o          = r_overflow;
    assign timeout_o           = r_timeout;

endmodule

`default_nettype wire

// File: tb/tb_uart_cmd_bridge.sv
// ============================================================================
//  Module      : tb_uart_cmd_bridge
//  Description : Self-checking bench for uart_cmd_bridge. Two instances
//                (MSB-first and LSB-first) share one byte stream and are
//                compared every cycle against a queue-based reference model.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_uart_cmd_bridge;

    localparam int c_DATA_W = 32;
    localparam int c_BYTES  = 4;
    localparam int c_DEPTH  = 4;
    localparam int c_TMO    = 100;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       tready;

    logic [2:0] level_m, level_l;
    logic       ovf_m, ovf_l, to_m, to_l;

    int n_vec = 0;
    int n_err = 0;

    // reference model state
    logic [7:0]  part[$];
    logic [31:0] q_m[$];
    logic [31:0] q_l[$];
    int          idle;
    bit          exp_ovf;
    bit          exp_to;

    always #5 clk = ~clk;

    uart_cmd_bridge_if #(.DATA_W(c_DATA_W)) if_m ();
    uart_cmd_bridge_if #(.DATA_W(c_DATA_W)) if_l ();

    assign if_m.rx_valid_i      = rx_valid;
    assign if_m.rx_data_i       = rx_data;
    assign if_m.m_axis_tready_i = tready;
    assign if_l.rx_valid_i      = rx_valid;
    assign if_l.rx_data_i       = rx_data;
    assign if_l.m_axis_tready_i = tready;

    uart_cmd_bridge #(
        .DATA_W(c_DATA_W), .FIFO_DEPTH(c_DEPTH), .MSB_FIRST(1), .TIMEOUT_CYC(c_TMO)
    ) u_msb (
        .clk(clk), .reset_i(reset), .bus(if_m.master),
        .level_o(level_m), .overflow_o(ovf_m), .timeout_o(to_m)
    );

    uart_cmd_bridge #(
        .DATA_W(c_DATA_W), .FIFO_DEPTH(c_DEPTH), .MSB_FIRST(0), .TIMEOUT_CYC(c_TMO)
    ) u_lsb (
        .clk(clk), .reset_i(reset), .bus(if_l.master),
        .level_o(level_l), .overflow_o(ovf_l), .timeout_o(to_l)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Compare both DUTs against the model; called away from the rising edge.
    task automatic check_outputs();
        chk("msb.level", 64'(level_m), 64'(q_m.size()));
        chk("lsb.level", 64'(level_l), 64'(q_l.size()));
        chk("msb.tvalid", 64'(if_m.m_axis_tvalid_o), 64'(q_m.size() != 0));
        chk("lsb.tvalid", 64'(if_l.m_axis_tvalid_o), 64'(q_l.size() != 0));
        if (q_m.size() != 0) begin
            chk("msb.tdata", 64'(if_m.m_axis_tdata_o), 64'(q_m[0]));
            chk("lsb.tdata", 64'(if_l.m_axis_tdata_o), 64'(q_l[0]));
        end
        chk("msb.overflow", 64'(ovf_m), 64'(exp_ovf));
        chk("lsb.overflow", 64'(ovf_l), 64'(exp_ovf));
        chk("msb.timeout", 64'(to_m), 64'(exp_to));
        chk("lsb.timeout", 64'(to_l), 64'(exp_to));
    endtask

    // One clock: check current state, drive inputs, advance the model to the
    // state expected after the coming rising edge, then step to the falling edge.
    task automatic step(input bit v, input logic [7:0] d, input bit rdy, input bit rst);
        bit pop, full;
        check_outputs();
        rx_valid = v;
        rx_data  = d;
        tready   = rdy;
        reset    = rst;
        exp_to   = 1'b0;
        if (rst) begin
            part.delete(); q_m.delete(); q_l.delete();
            idle = 0; exp_ovf = 1'b0;
        end else begin
            full = (q_m.size() == c_DEPTH);
            pop  = (q_m.size() != 0) && rdy;
            if (pop) begin
                void'(q_m.pop_front());
                void'(q_l.pop_front());
            end
            if (v) begin
                part.push_back(d);
                idle = 0;
                if (part.size() == c_BYTES) begin
                    if (!full || pop) begin
                        q_m.push_back({part[0], part[1], part[2], part[3]});
                        q_l.push_back({part[3], part[2], part[1], part[0]});
                    end else begin
                        exp_ovf = 1'b1;
                    end
                    part.delete();
                end
            end else if (part.size() != 0) begin
                idle++;
                if (idle == c_TMO) begin
                    part.delete();
                    idle   = 0;
                    exp_to = 1'b1;
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send_word(input logic [31:0] w, input bit rdy);
        for (int i = 3; i >= 0; i--)
            step(1'b1, w[8*i +: 8], rdy, 1'b0);
    endtask

    task automatic do_reset();
        step(1'b1, 8'hEE, 1'b0, 1'b1);
    endtask

    initial begin
        bit rdy;
        rx_valid = 1'b0; rx_data = 8'h00; tready = 1'b0; reset = 1'b1;
        idle = 0; exp_ovf = 1'b0; exp_to = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);

        // reset state
        chk("reset.level", 64'(level_m), 64'd0);
        chk("reset.tvalid", 64'(if_m.m_axis_tvalid_o), 64'd0);
        chk("reset.overflow", 64'(ovf_m), 64'd0);

        // basic word, both byte orders, valid the cycle after the last byte
        send_word(32'h12345678, 1'b1);
        chk("basic.tvalid", 64'(if_m.m_axis_tvalid_o), 64'd1);
        chk("basic.msb", 64'(if_m.m_axis_tdata_o), 64'h12345678);
        chk("basic.lsb", 64'(if_l.m_axis_tdata_o), 64'h78563412);
        step(1'b0, 8'h00, 1'b1, 1'b0);

        // overflow: five words into a stalled FIFO, then drain
        for (int w = 0; w < 5; w++)
            send_word(32'hA0B0C0D0 + 32'(w * 32'h01010101), 1'b0);
        chk("ovf.level", 64'(level_m), 64'd4);
        chk("ovf.flag", 64'(ovf_m), 64'd1);
        repeat (3) step(1'b0, 8'h00, 1'b0, 1'b0);
        chk("ovf.head", 64'(if_m.m_axis_tdata_o), 64'hA0B0C0D0);
        repeat (6) step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("ovf.sticky", 64'(ovf_m), 64'd1);

        // simultaneous push and pop while full
        do_reset();
        for (int w = 0; w < 4; w++)
            send_word(32'h11223344 ^ 32'(w), 1'b0);
        for (int i = 0; i < 3; i++)
            step(1'b1, 8'h50 + 8'(i), 1'b0, 1'b0);
        step(1'b1, 8'h53, 1'b1, 1'b0);
        chk("fullpp.level", 64'(level_m), 64'd4);
        chk("fullpp.overflow", 64'(ovf_m), 64'd0);
        chk("fullpp.head", 64'(if_m.m_axis_tdata_o), 64'h11223345);
        repeat (6) step(1'b0, 8'h00, 1'b1, 1'b0);

        // reset mid-word discards FIFO and partial word
        send_word(32'hDEADBEEF, 1'b0);
        for (int i = 0; i < 3; i++)
            step(1'b1, 8'h90 + 8'(i), 1'b0, 1'b0);
        do_reset();
        chk("rst.level", 64'(level_m), 64'd0);
        chk("rst.tvalid", 64'(if_m.m_axis_tvalid_o), 64'd0);
        send_word(32'hCAFEF00D, 1'b0);
        chk("rst.clean", 64'(if_m.m_axis_tdata_o), 64'hCAFEF00D);
        step(1'b0, 8'h00, 1'b1, 1'b0);

        // timeout after 100 idle cycles, exactly one pulse
        step(1'b1, 8'h01, 1'b1, 1'b0);
        step(1'b1, 8'h02, 1'b1, 1'b0);
        repeat (c_TMO - 1) step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("tmo.early", 64'(to_m), 64'd0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("tmo.pulse", 64'(to_m), 64'd1);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("tmo.once", 64'(to_m), 64'd0);
        send_word(32'hAABBCCDD, 1'b0);
        chk("tmo.after", 64'(if_m.m_axis_tdata_o), 64'hAABBCCDD);
        step(1'b0, 8'h00, 1'b1, 1'b0);

        // byte arriving in the expiry cycle suppresses the timeout
        step(1'b1, 8'h31, 1'b1, 1'b0);
        step(1'b1, 8'h32, 1'b1, 1'b0);
        repeat (c_TMO - 1) step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b1, 8'h33, 1'b0, 1'b0);
        chk("race.notmo", 64'(to_m), 64'd0);
        step(1'b1, 8'h34, 1'b0, 1'b0);
        chk("race.word", 64'(if_m.m_axis_tdata_o), 64'h31323334);
        step(1'b0, 8'h00, 1'b1, 1'b0);

        // randomized traffic with stalls, long gaps and occasional resets
        for (int c = 0; c < 4000; c++) begin
            rdy = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 299) == 0) begin
                repeat ($urandom_range(95, 110)) step(1'b0, 8'h00, rdy, 1'b0);
            end else if ($urandom_range(0, 799) == 0) begin
                step(1'b1, 8'($urandom), rdy, 1'b1);
            end else begin
                step(($urandom_range(0, 2) == 0), 8'($urandom), rdy, 1'b0);
            end
        end
        check_outputs();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
